// File: rtl/axis_packetizer_pkg.sv
// Shared types and constants for the AXI4-Stream packetizer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_packetizer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Each skid entry carries the data word plus its tlast tag.
    localparam int unsigned SKID_TAG_BITS = 1;

    function automatic int unsigned skid_width(input int unsigned tdata_w);
        return tdata_w + SKID_TAG_BITS;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: decouples the upstream ready from downstream ready.
// Latency: 1 cycle from slave handshake to m_vld; 1 beat/cycle when m_rdy=1.
// Backpressure: holds up to 2 beats in order; s_rdy is registered (~full).
// Ports: aclk/areset (sync, active-high); s_vld/s_rdy/s_dat slave side;
//        m_vld/m_rdy/m_dat master side (m_dat reads 0 while m_vld=0).
module axis_skid_buffer #(
    parameter int unsigned DATA_WIDTH = 33
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_vld,
    output logic                  s_rdy,
    input  logic [DATA_WIDTH-1:0] s_dat,
    output logic                  m_vld,
    input  logic                  m_rdy,
    output logic [DATA_WIDTH-1:0] m_dat
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  push, pop;

    // Ready and valid come straight from the occupancy register.
    assign s_rdy = (cnt_q != 2'd2);
    assign m_vld = (cnt_q != 2'd0);
    assign m_dat = m_vld ? mem_q[rd_ptr_q] : '0;

    assign push = s_vld & s_rdy;
    assign pop  = m_vld & m_rdy;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Frames an AXI4-Stream into fixed cfg_data+1 beat packets by tagging tlast.
// Latency: 1 cycle from slave handshake to m_axis_tvalid via a skid buffer.
// Backpressure: s_axis_tready is registered; drops when 2 beats are buffered.
// Ports: aclk/areset (sync, active-high); cfg_data (length-1), cfg_enable
//        (run request, stops only at packet boundaries); sts_data (completed
//        packets on master side); s_axis_* slave stream; m_axis_* master stream.
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32,
    parameter int unsigned STS_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_enable,
    output logic [STS_WIDTH-1:0]        sts_data,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
);

    localparam int unsigned SW = skid_width(AXIS_TDATA_WIDTH);

    state_t                state_q, state_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0] len_q, len_d;
    logic [STS_WIDTH-1:0]  sts_q, sts_d;

    logic                  run;
    logic                  skid_s_rdy;
    logic [SW-1:0]         skid_m_dat;
    logic                  accept;
    logic                  beat_last;
    logic [CNTR_WIDTH-1:0] cur_len;

    assign run           = (state_q == ST_RUN);
    assign s_axis_tready = run & skid_s_rdy;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // The first beat of a packet compares against cfg_data directly because
    // len_q is only being loaded on that same edge.
    assign cur_len   = (cnt_q == '0) ? cfg_data : len_q;
    assign beat_last = (cnt_q == cur_len);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sts_d   = sts_q;

        if (accept) begin
            if (cnt_q == '0) begin
                len_d = cfg_data;
            end
            cnt_d = beat_last ? '0 : cnt_q + CNTR_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Leave only when the packet is closed: either nothing is in
                // flight, or this very beat is its tlast. A beat accepted at
                // counter 0 opens a packet that must then be completed.
                if (!cfg_enable) begin
                    if (accept ? beat_last : (cnt_q == '0)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            sts_d = sts_q + STS_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sts_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sts_q   <= sts_d;
        end
    end

    assign sts_data = sts_q;

    axis_skid_buffer #(
        .DATA_WIDTH (SW)
    ) u_skid (
        .aclk   (aclk),
        .areset (areset),
        .s_vld  (s_axis_tvalid & run),
        .s_rdy  (skid_s_rdy),
        .s_dat  ({s_axis_tdata, beat_last}),
        .m_vld  (m_axis_tvalid),
        .m_rdy  (m_axis_tready),
        .m_dat  (skid_m_dat)
    );

    assign m_axis_tdata = skid_m_dat[SW-1:1];
    assign m_axis_tlast = skid_m_dat[0];

endmodule
